// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the calculator sequencing controller.
//   OPW      operand width (two 4-bit digits per operand)
//   ITER     number of iterations of the multi-cycle multiply/divide
//   OP_*     2-bit operation codes presented on op_sel
//   state_t  controller FSM states
package calc_pkg;

    localparam int OPW  = 8;
    localparam int ITER = 8;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: conditions one raw active-low push-button.
//   clk    system clock
//   reset  synchronous active-high reset (key treated as released)
//   key_n  raw active-low button level, asynchronous to clk
//   press  one-cycle pulse when the key has been stably low for DEB_CNT cycles
// The accepted state flips only after DEB_CNT consecutive synchronized samples
// disagree with it, so a new press needs DEB_CNT high samples first, and any
// shorter glitch restarts the count.
module key_debounce #(
    parameter int DEB_CNT = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int            CW       = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic          sync1;
    logic          sync2;
    logic          held;     // accepted state: 1 = pressed
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            held  <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            // sync2 is active-low, so it agrees with held when they differ.
            if (sync2 == ~held) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                held  <= ~held;
                press <= ~held;   // pulse only on the released->pressed flip
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: sequencing controller for the 2-digit-operand calculator.
//   clk, reset      system clock, synchronous active-high reset
//   key_wr_n        raw active-low "write digit" button
//   key_exec_n      raw active-low "execute" button
//   key_clr_n       raw active-low "clear" button
//   sel_digit       digit slot: 0=A hi, 1=A lo, 2=B hi, 3=B lo
//   digit_in        nibble to write
//   op_sel          0=add, 1=sub, 2=mul, 3=div
//   digits_out      {A hi, A lo, B hi, B lo}, live operand registers
//   result          last completed result (div: {remainder, quotient})
//   busy            high from LOAD through FIN
//   done            one-cycle pulse in FIN, the cycle result first shows the new value
//   err             sticky divide-by-zero flag, cleared by LOAD or clear
// Pulse semantics: the three debounced key pulses are single-cycle events that
// are acted on only in the cycle they are high; nothing is queued. Priority is
// clear > exec > write, and write/exec are only honoured in IDLE.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int DEB_CNT = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_wr_n,
    input  logic        key_exec_n,
    input  logic        key_clr_n,
    input  logic [1:0]  sel_digit,
    input  logic [3:0]  digit_in,
    input  logic [1:0]  op_sel,
    output logic [15:0] digits_out,
    output logic [15:0] result,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] STEP_LAST = 3'(ITER - 1);

    logic wr_p;
    logic exec_p;
    logic clr_p;

    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_wr (
        .clk(clk), .reset(reset), .key_n(key_wr_n), .press(wr_p)
    );
    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_exec (
        .clk(clk), .reset(reset), .key_n(key_exec_n), .press(exec_p)
    );
    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_clr (
        .clk(clk), .reset(reset), .key_n(key_clr_n), .press(clr_p)
    );

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      digits;
    logic [OPW-1:0]   a_q;
    logic [OPW-1:0]   b_q;
    logic [1:0]       op_q;
    logic [OPW-1:0]   acc_hi;
    logic [OPW-1:0]   acc_lo;
    logic [2:0]       step;
    logic [15:0]      result_q;
    logic             err_q;

    // One iteration of the shared ALU. Both algorithms keep a 16-bit
    // {acc_hi, acc_lo} pair so that the final value is the result directly:
    //   mul: acc_lo starts as the multiplier and shifts right while partial
    //        sums enter acc_hi; after 8 steps the pair is the product.
    //   div: acc_lo starts as the dividend and shifts left into the partial
    //        remainder in acc_hi; quotient bits fill acc_lo from the right.
    logic [OPW:0]   mul_sum;
    logic [OPW:0]   div_trial;
    logic [OPW-1:0] it_hi;
    logic [OPW-1:0] it_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
        div_trial = {acc_hi, acc_lo[OPW-1]} - {1'b0, b_q};
        it_hi     = acc_hi;
        it_lo     = acc_lo;
        if (op_q == OP_MUL) begin
            {it_hi, it_lo} = {mul_sum, acc_lo[OPW-1:1]};
        end else if (div_trial[OPW]) begin
            // trial went negative: keep the shifted remainder, quotient bit 0
            it_hi = {acc_hi[OPW-2:0], acc_lo[OPW-1]};
            it_lo = {acc_lo[OPW-2:0], 1'b0};
        end else begin
            it_hi = div_trial[OPW-1:0];
            it_lo = {acc_lo[OPW-2:0], 1'b1};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (exec_p) state_nxt = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (op_q == OP_MUL || (op_q == OP_DIV && b_q != '0)) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = FIN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (step == STEP_LAST) state_nxt = FIN;
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clr_p) state_nxt = IDLE;
    end

    // Operand registers, snapshot, ALU accumulator and result
    always_ff @(posedge clk) begin
        if (reset || clr_p) begin
            digits   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            acc_hi   <= '0;
            acc_lo   <= '0;
            step     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (exec_p) begin
                        // snapshot on entry so LOAD can decide from stable copies
                        a_q   <= digits[15:8];
                        b_q   <= digits[7:0];
                        op_q  <= op_sel;
                        err_q <= 1'b0;
                    end else if (wr_p) begin
                        case (sel_digit)
                            2'd0:    digits[15:12] <= digit_in;
                            2'd1:    digits[11:8]  <= digit_in;
                            2'd2:    digits[7:4]   <= digit_in;
                            default: digits[3:0]   <= digit_in;
                        endcase
                    end
                end
                LOAD: begin
                    step   <= '0;
                    acc_hi <= '0;
                    acc_lo <= (op_q == OP_MUL) ? b_q : a_q;
                    case (op_q)
                        OP_ADD: result_q <= 16'(a_q) + 16'(b_q);
                        OP_SUB: result_q <= 16'(a_q) - 16'(b_q);
                        OP_DIV: begin
                            if (b_q == '0) begin
                                result_q <= '0;
                                err_q    <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                RUN: begin
                    acc_hi <= it_hi;
                    acc_lo <= it_lo;
                    step   <= step + 1'b1;
                    if (step == STEP_LAST) result_q <= {it_hi, it_lo};
                end
                default: ;
            endcase
        end
    end

    assign digits_out = digits;
    assign result     = result_q;
    assign err        = err_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed plus randomized checks of calc_seq_ctrl against a
// behavioural arithmetic model, with DEB_CNT reduced to 4.
module tb_calc_seq_ctrl;

    localparam int DEB = 4;

    logic        clk;
    logic        reset;
    logic        key_wr_n;
    logic        key_exec_n;
    logic        key_clr_n;
    logic [1:0]  sel_digit;
    logic [3:0]  digit_in;
    logic [1:0]  op_sel;
    logic [15:0] digits_out;
    logic [15:0] result;
    logic        busy;
    logic        done;
    logic        err;

    int tests  = 0;
    int failed = 0;

    logic [3:0]  m_dig [4];     // model operand nibbles, slot order as sel_digit
    logic [15:0] exp_q [$];     // expected results, pushed at exec, popped at done

    calc_seq_ctrl #(.DEB_CNT(DEB)) dut (
        .clk(clk), .reset(reset),
        .key_wr_n(key_wr_n), .key_exec_n(key_exec_n), .key_clr_n(key_clr_n),
        .sel_digit(sel_digit), .digit_in(digit_in), .op_sel(op_sel),
        .digits_out(digits_out), .result(result),
        .busy(busy), .done(done), .err(err)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #(400000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_digits();
        return {m_dig[0], m_dig[1], m_dig[2], m_dig[3]};
    endfunction

    // Reference arithmetic: returns {err, result}
    function automatic logic [16:0] ref_calc(input logic [1:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        int ai;
        int bi;
        int r;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        case (op)
            2'd0: r = ai + bi;
            2'd1: r = ai - bi;
            2'd2: r = ai * bi;
            default: begin
                if (bi == 0) return {1'b1, 16'h0000};
                r = (ai % bi) * 256 + (ai / bi);
            end
        endcase
        return {1'b0, 16'(r)};
    endfunction

    // ---------------- drivers ----------------
    task automatic set_key(input int k, input logic v);
        case (k)
            0:       key_wr_n   = v;
            1:       key_exec_n = v;
            default: key_clr_n  = v;
        endcase
    endtask

    task automatic press_key(input int k, input int hold);
        set_key(k, 1'b0);
        repeat (hold) @(negedge clk);
        set_key(k, 1'b1);
        repeat (DEB + 4) @(negedge clk);
    endtask

    task automatic write_digit(input int s, input logic [3:0] v);
        sel_digit = 2'(s);
        digit_in  = v;
        press_key(0, DEB + 4);
        m_dig[s] = v;
        check("digits_write", digits_out, model_digits());
    endtask

    task automatic write_operands(input logic [7:0] a, input logic [7:0] b);
        write_digit(0, a[7:4]);
        write_digit(1, a[3:0]);
        write_digit(2, b[7:4]);
        write_digit(3, b[3:0]);
    endtask

    // Issue one operation and check timing, result and err against the model.
    // Cycle 1 is the first cycle busy is seen.
    task automatic run_op(input logic [1:0] op, input bit wr_during);
        logic [7:0]  a;
        logic [7:0]  b;
        logic [16:0] r;
        logic        exp_e;
        int          exp_c;
        int          c;
        a     = {m_dig[0], m_dig[1]};
        b     = {m_dig[2], m_dig[3]};
        r     = ref_calc(op, a, b);
        exp_e = r[16];
        exp_c = (op == 2'd2 || (op == 2'd3 && b != 8'h00)) ? 10 : 2;
        exp_q.push_back(r[15:0]);
        op_sel     = op;
        key_exec_n = 1'b0;
        c = 0;
        while (!busy && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("busy_rise", busy, 1);
        check("err_at_load", err, 0);
        check("done_at_load", done, 0);
        op_sel = 2'($urandom_range(0, 3));   // must not disturb the running op
        if (wr_during) begin
            sel_digit = 2'd0;
            digit_in  = ~m_dig[0];
            key_wr_n  = 1'b0;
        end
        c = 1;
        while (!done && busy && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("done_cycle", c, exp_c);
        check("result", result, exp_q.pop_front());
        check("err_fin", err, exp_e);
        @(negedge clk);
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("err_sticky", err, exp_e);
        key_exec_n = 1'b1;
        key_wr_n   = 1'b1;
        repeat (DEB + 4) @(negedge clk);
        check("digits_after_op", digits_out, model_digits());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         c;
        bit         seen_done;
        logic [3:0] v1;
        logic [3:0] v2;
        logic [7:0] ra;
        logic [7:0] rb;

        key_wr_n   = 1'b1;
        key_exec_n = 1'b1;
        key_clr_n  = 1'b1;
        sel_digit  = 2'd0;
        digit_in   = 4'h0;
        op_sel     = 2'd0;
        do_reset();

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 16'h0000);
        check("rst_digits", digits_out, 16'h0000);

        // add / sub / mul
        write_operands(8'h12, 8'h34);
        check("digits_1234", digits_out, 16'h1234);
        run_op(2'd0, 1'b0);
        check("add_const", result, 16'h0046);
        run_op(2'd1, 1'b0);
        check("sub_const", result, 16'hFFDE);
        write_operands(8'hFF, 8'hFF);
        run_op(2'd2, 1'b0);
        check("mul_const", result, 16'hFE01);

        // divide, divide by zero, err cleared by next op
        write_operands(8'hC8, 8'h07);
        run_op(2'd3, 1'b0);
        check("div_const", result, 16'h041C);
        check("div_err", err, 0);
        write_digit(2, 4'h0);
        write_digit(3, 4'h0);
        run_op(2'd3, 1'b0);
        check("div0_const", result, 16'h0000);
        check("div0_err", err, 1);
        run_op(2'd0, 1'b0);
        check("err_cleared", err, 0);

        // glitch shorter than DEB_CNT: no write
        sel_digit = 2'd1;
        digit_in  = ~m_dig[1];
        key_wr_n  = 1'b0;
        repeat (DEB - 1) @(negedge clk);
        key_wr_n  = 1'b1;
        repeat (DEB + 4) @(negedge clk);
        check("glitch_no_write", digits_out, model_digits());

        // long hold: exactly one write (a second pulse would load v2)
        v1 = ~m_dig[1];
        v2 = v1 ^ 4'h5;
        sel_digit = 2'd1;
        digit_in  = v1;
        key_wr_n  = 1'b0;
        repeat (10) @(negedge clk);
        digit_in  = v2;
        repeat (40) @(negedge clk);
        key_wr_n  = 1'b1;
        repeat (DEB + 4) @(negedge clk);
        m_dig[1] = v1;
        check("long_hold_one_write", digits_out, model_digits());
        write_digit(1, v2);
        check("repress_write", digits_out[11:8], v2);

        // clear during a multiply aborts it
        write_operands(8'h0F, 8'h0E);
        op_sel     = 2'd2;
        key_exec_n = 1'b0;
        c = 0;
        while (!busy && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("clr_busy_rise", busy, 1);
        key_clr_n = 1'b0;
        seen_done = 1'b0;
        c = 1;
        while (busy && c < 20) begin
            @(negedge clk);
            c++;
            if (done) seen_done = 1'b1;
        end
        check("clr_abort_early", (c < 10), 1);
        check("clr_no_done", seen_done, 0);
        check("clr_busy", busy, 0);
        check("clr_result", result, 16'h0000);
        check("clr_digits", digits_out, 16'h0000);
        check("clr_err", err, 0);
        key_clr_n  = 1'b1;
        key_exec_n = 1'b1;
        repeat (DEB + 4) @(negedge clk);
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;

        // write attempted while busy is ignored
        write_operands(8'h23, 8'h45);
        run_op(2'd2, 1'b1);
        check("busy_write_ignored", digits_out, 16'h2345);

        // reset during RUN
        write_operands(8'h11, 8'h22);
        op_sel     = 2'd2;
        key_exec_n = 1'b0;
        c = 0;
        while (!busy && c < 40) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        reset      = 1'b1;
        key_exec_n = 1'b1;
        @(negedge clk);
        check("rrun_busy", busy, 0);
        check("rrun_done", done, 0);
        check("rrun_result", result, 16'h0000);
        check("rrun_digits", digits_out, 16'h0000);
        check("rrun_err", err, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        repeat (DEB + 4) @(negedge clk);
        check("rrun_idle", busy, 0);
        write_operands(8'h01, 8'h01);
        run_op(2'd0, 1'b0);
        check("post_reset_add", result, 16'h0002);

        // randomized operations against the model
        for (int n = 0; n < 12; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (n % 4 == 3) ? 8'h00 : 8'($urandom_range(0, 255));
            write_operands(ra, rb);
            run_op(2'($urandom_range(0, 3)), 1'b0);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
